// File: rtl/mmcm_reconfig_ctrl.sv
// mmcm_reconfig_ctrl: run-time MMCM reprogramming sequencer over the DRP.
// Holds the MMCM in reset, applies a profile of masked read-modify-write DRP
// updates fetched from an external 1-cycle-latency table, releases reset and
// waits for lock. It is the only driver of the MMCM reset and the DRP ports.
// Ports:
//   i_clk, i_rst_n          control clock, async active-low reset
//   i_req, i_profile        start pulse and profile select (sampled in IDLE)
//   o_busy, o_done, o_err   status; o_done/o_err are one-cycle pulses
//   o_err_code              01 = DRDY timeout, 10 = lock timeout
//   o_tbl_addr, i_tbl_data  profile table {drp_addr[38:32], mask[31:16], data[15:0]}
//   o_daddr, o_den, o_dwe, o_di, i_do, i_drdy   DRP
//   o_mmcm_rst, i_locked    MMCM reset (active high) and async lock input
//   o_clk_ready             generated clock usable downstream
// Optional: define MMCM_LOCK_RECOVER_EN to re-run the last profile when lock
// is lost while ready.
module mmcm_reconfig_ctrl #(
    parameter int NUM_PROFILES = 4,
    parameter int ENTRIES      = 8,
    parameter int RST_HOLD     = 4,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536,
    localparam int PW = $clog2(NUM_PROFILES),
    localparam int AW = $clog2(NUM_PROFILES * ENTRIES)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req,
    input  logic [PW-1:0] i_profile,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [1:0]    o_err_code,
    output logic [AW-1:0] o_tbl_addr,
    input  logic [38:0]   i_tbl_data,
    output logic [6:0]    o_daddr,
    output logic          o_den,
    output logic          o_dwe,
    output logic [15:0]   o_di,
    input  logic [15:0]   i_do,
    input  logic          i_drdy,
    output logic          o_mmcm_rst,
    input  logic          i_locked,
    output logic          o_clk_ready
);
    localparam int IW = $clog2(ENTRIES);
    // One shared counter serves reset hold, DRDY and lock timeouts; the lock
    // timeout is the longest of the three.
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] DRDY_MAX = CW'(DRDY_TIMEOUT - 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(ENTRIES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RST_HOLD, S_FETCH, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT,
        S_RELEASE, S_WAIT_LOCK, S_DONE, S_ERR
    } state_t;

    state_t        state;
    logic [PW-1:0] prof;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [15:0]   mask;
    logic [15:0]   wdata;
    logic [1:0]    lock_ff;
    logic          locked_sync;
    logic          start;

    assign locked_sync = lock_ff[1];

`ifdef MMCM_LOCK_RECOVER_EN
    assign start = i_req || (o_clk_ready && !locked_sync);
`else
    assign start = i_req;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_ff <= '0;
        end else begin
            lock_ff <= {lock_ff[0], i_locked};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // Power-up goes straight to lock wait so the default profile locks.
            state       <= S_WAIT_LOCK;
            prof        <= '0;
            idx         <= '0;
            cnt         <= '0;
            mask        <= '0;
            wdata       <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_err_code  <= 2'b00;
            o_den       <= 1'b0;
            o_dwe       <= 1'b0;
            o_daddr     <= '0;
            o_di        <= '0;
            o_tbl_addr  <= '0;
            o_mmcm_rst  <= 1'b1;
            o_clk_ready <= 1'b0;
        end else begin
            o_den  <= 1'b0;
            o_dwe  <= 1'b0;
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_clk_ready <= o_clk_ready & locked_sync;
                    if (start) begin
                        if (i_req) prof <= i_profile;
                        o_busy      <= 1'b1;
                        o_clk_ready <= 1'b0;
                        o_mmcm_rst  <= 1'b1;
                        o_err_code  <= 2'b00;
                        idx         <= '0;
                        cnt         <= '0;
                        state       <= S_RST_HOLD;
                    end
                end
                S_RST_HOLD: begin
                    if (cnt == HOLD_MAX) begin
                        o_tbl_addr <= AW'(prof) * AW'(ENTRIES);
                        state      <= S_FETCH;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // Address was presented on entry; table data is valid in S_RD.
                S_FETCH: state <= S_RD;
                S_RD: begin
                    o_den   <= 1'b1;
                    o_daddr <= i_tbl_data[38:32];
                    mask    <= i_tbl_data[31:16];
                    wdata   <= i_tbl_data[15:0];
                    cnt     <= '0;
                    state   <= S_RD_WAIT;
                end
                S_WR: begin
                    o_den <= 1'b1;
                    o_dwe <= 1'b1;
                    cnt   <= '0;
                    state <= S_WR_WAIT;
                end
                S_RD_WAIT, S_WR_WAIT: begin
                    if (i_drdy) begin
                        if (state == S_RD_WAIT) begin
                            // Mask bit set keeps the current register bit.
                            o_di  <= (i_do & mask) | (wdata & ~mask);
                            state <= S_WR;
                        end else if (idx == IDX_LAST) begin
                            state <= S_RELEASE;
                        end else begin
                            idx        <= idx + IW'(1);
                            o_tbl_addr <= o_tbl_addr + AW'(1);
                            state      <= S_FETCH;
                        end
                    end else if (cnt == DRDY_MAX) begin
                        o_err_code  <= 2'b01;
                        o_err       <= 1'b1;
                        o_busy      <= 1'b0;
                        o_mmcm_rst  <= 1'b1;
                        o_clk_ready <= 1'b0;
                        state       <= S_ERR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RELEASE: begin
                    o_mmcm_rst <= 1'b0;
                    cnt        <= '0;
                    state      <= S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    o_mmcm_rst <= 1'b0;
                    if (locked_sync) begin
                        o_done      <= 1'b1;
                        o_clk_ready <= 1'b1;
                        o_busy      <= 1'b0;
                        state       <= S_DONE;
                    end else if (cnt == LOCK_MAX) begin
                        o_err_code  <= 2'b10;
                        o_err       <= 1'b1;
                        o_busy      <= 1'b0;
                        o_mmcm_rst  <= 1'b1;
                        o_clk_ready <= 1'b0;
                        state       <= S_ERR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmcm_reconfig_ctrl.sv
// tb_mmcm_reconfig_ctrl: scoreboard bench with table, DRP and MMCM lock models.
module tb_mmcm_reconfig_ctrl;
    localparam int NE = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  profile = 2'd0;
    logic        busy, done, err, den, dwe, mmcm_rst, clk_ready;
    logic [1:0]  err_code;
    logic [4:0]  tbl_addr;
    logic [38:0] tbl_data = '0;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic [15:0] drp_do = '0;
    logic        drdy = 1'b0;
    logic        locked = 1'b0;

    mmcm_reconfig_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_profile(profile),
        .o_busy(busy), .o_done(done), .o_err(err), .o_err_code(err_code),
        .o_tbl_addr(tbl_addr), .i_tbl_data(tbl_data),
        .o_daddr(daddr), .o_den(den), .o_dwe(dwe), .o_di(di),
        .i_do(drp_do), .i_drdy(drdy),
        .o_mmcm_rst(mmcm_rst), .i_locked(locked), .o_clk_ready(clk_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_rd = 0;
    int n_wr = 0;
    int hang_rd = 0;
    int rd_cyc = 0;
    int rel_cyc = 0;
    int end_cyc = 0;
    int lock_cnt = 0;
    int pend = 0;
    int res;
    logic        lock_en = 1'b1;
    logic        drop = 1'b0;
    logic        prev_rst = 1'b1;
    logic [15:0] rd_val = 16'hFFFF;
    logic [4:0]  last_addr = '0;
    logic [38:0] tbl [32];
    logic [6:0]  exp_rd [$];
    logic [22:0] exp_wr [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Table (1-cycle latency), DRP responder, lock model and DRP monitor.
    initial forever begin
        logic [22:0] w;
        logic [6:0]  a;
        @(negedge clk);
        tbl_data = tbl[last_addr];
        last_addr = tbl_addr;
        drdy = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                drdy = 1'b1;
                drp_do = rd_val;
            end
        end
        if (mmcm_rst) lock_cnt = 0;
        else if (lock_en && lock_cnt < 1000) lock_cnt++;
        locked = (lock_cnt >= 100) && !drop;
        if (prev_rst && !mmcm_rst) rel_cyc = cyc;
        prev_rst = mmcm_rst;
        if (rst_n) begin
            if (dwe) chk("dwe_with_den", den, 1);
            if (den) begin
                chk("rst_hi_den", mmcm_rst, 1);
                if (dwe) begin
                    n_wr++;
                    chk("wr_expected", exp_wr.size() != 0, 1);
                    if (exp_wr.size() != 0) begin
                        w = exp_wr.pop_front();
                        chk("wr_addr", daddr, w[22:16]);
                        chk("wr_data", di, w[15:0]);
                    end
                    pend = 2;
                end else begin
                    n_rd++;
                    rd_cyc = cyc;
                    chk("rd_expected", exp_rd.size() != 0, 1);
                    if (exp_rd.size() != 0) begin
                        a = exp_rd.pop_front();
                        chk("rd_addr", daddr, a);
                    end
                    if (n_rd != hang_rd) pend = 2;
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_code"}, err_code, 0);
        chk({tag, "_den"}, den, 0);
        chk({tag, "_dwe"}, dwe, 0);
        chk({tag, "_daddr"}, daddr, 0);
        chk({tag, "_di"}, di, 0);
        chk({tag, "_taddr"}, tbl_addr, 0);
        chk({tag, "_mrst"}, mmcm_rst, 1);
        chk({tag, "_ready"}, clk_ready, 0);
    endtask

    task automatic push_prof(input int p, input logic [15:0] rdv);
        logic [38:0] t;
        for (int e = 0; e < NE; e++) begin
            t = tbl[p * NE + e];
            exp_rd.push_back(t[38:32]);
            exp_wr.push_back({t[38:32], (rdv & t[31:16]) | (t[15:0] & ~t[31:16])});
        end
    endtask

    task automatic start_prof(input int p, input logic [15:0] rdv);
        rd_val = rdv;
        n_rd = 0;
        n_wr = 0;
        push_prof(p, rdv);
        @(posedge clk);
        #1 req = 1'b1;
        profile = 2'(p);
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int r);
        r = 0;
        for (int i = 0; i < budget && r == 0; i++) begin
            @(negedge clk);
            if (done) r = 1;
            else if (err) r = 2;
        end
        end_cyc = cyc;
    endtask

    task automatic run_ok(input string tag, input int p, input logic [15:0] rdv);
        start_prof(p, rdv);
        wait_end(2000, res);
        chk({tag, "_done"}, res, 1);
        chk({tag, "_rds"}, n_rd, NE);
        chk({tag, "_wrs"}, n_wr, NE);
        chk({tag, "_ready"}, clk_ready, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            logic [15:0] m, d;
            m = (i / NE == 2) ? 16'hF000 : 16'(i * 32'h0F0F);
            d = (i / NE == 2) ? 16'h0123 : 16'(i * 32'h1357);
            tbl[i] = {7'(i) ^ 7'h40, m, d};
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_rd = 0;
        n_wr = 0;
        wait_end(500, res);
        chk("pu_done", res, 1);
        chk("pu_ready", clk_ready, 1);
        chk("pu_no_den", n_rd + n_wr, 0);

        run_ok("p2", 2, 16'hFFFF);
        run_ok("p1", 1, 16'h0000);
        run_ok("p3", 3, 16'hA5A5);

        hang_rd = 3;
        start_prof(0, 16'h1234);
        wait_end(2000, res);
        chk("to_err", res, 2);
        chk("to_lat", end_cyc - rd_cyc, 64);
        chk("to_code", err_code, 1);
        chk("to_mrst", mmcm_rst, 1);
        chk("to_busy", busy, 0);
        chk("to_rds", n_rd, 3);
        exp_rd.delete();
        exp_wr.delete();
        hang_rd = 0;
        repeat (5) @(negedge clk);
        chk("to_code_hold", err_code, 1);
        chk("to_not_ready", clk_ready, 0);

        lock_en = 1'b0;
        start_prof(1, 16'h00FF);
        wait_end(70000, res);
        chk("lk_err", res, 2);
        chk("lk_lat", end_cyc - rel_cyc, 65536);
        chk("lk_code", err_code, 2);
        chk("lk_rds", n_rd, NE);
        lock_en = 1'b1;
        run_ok("retry", 1, 16'h00FF);
        chk("retry_code_clr", err_code, 0);

        start_prof(2, 16'h5A5A);
        for (int i = 0; i < 500 && n_wr == 0; i++) @(negedge clk);
        @(posedge clk);
        #1 req = 1'b1;
        profile = 2'd1;
        @(posedge clk);
        #1 req = 1'b0;
        wait_end(2000, res);
        chk("ign_done", res, 1);
        chk("ign_rds", n_rd, NE);
        repeat (40) @(negedge clk);
        chk("ign_idle", busy, 0);
        chk("ign_no_rerun", n_rd, NE);

        start_prof(0, 16'h0F0F);
        for (int i = 0; i < 500 && n_rd < 3; i++) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_reset("mid");
        exp_rd.delete();
        exp_wr.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_rd = 0;
        n_wr = 0;
        wait_end(500, res);
        chk("mid_pu_done", res, 1);
        chk("mid_no_den", n_rd + n_wr, 0);

        run_ok("pre_drop", 3, 16'hC3C3);
        n_rd = 0;
        n_wr = 0;
`ifdef MMCM_LOCK_RECOVER_EN
        push_prof(3, 16'hC3C3);
`endif
        @(posedge clk);
        #1 drop = 1'b1;
        repeat (4) @(negedge clk);
        chk("drop_ready", clk_ready, 0);
        repeat (6) @(negedge clk);
        drop = 1'b0;
`ifdef MMCM_LOCK_RECOVER_EN
        wait_end(2000, res);
        chk("rec_done", res, 1);
        chk("rec_rds", n_rd, NE);
        chk("rec_ready", clk_ready, 1);
`else
        repeat (200) @(negedge clk);
        chk("norec_busy", busy, 0);
        chk("norec_den", n_rd + n_wr, 0);
        chk("norec_ready", clk_ready, 0);
`endif
        chk("sb_rd_empty", exp_rd.size(), 0);
        chk("sb_wr_empty", exp_wr.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mmcm_reconfig_ctrl.md
Name: mmcm_reconfig_ctrl

Overview:
- Sequencer that reprograms the MMCM clock generator at run time through its dynamic reconfiguration port (DRP).
- On request it holds the MMCM in reset and applies a profile of masked read-modify-write register updates taken from an external synchronous table. It then releases reset and waits for lock.
- Sits between system control logic and the clock generator; it is the only driver of MMCM RST and the DRP ports. Runs on the free-running input-side clock.

Parameters:
- NUM_PROFILES, 4, number of selectable frequency profiles.
- ENTRIES, 8, DRP register writes per profile.
- RST_HOLD, 4, cycles MMCM reset is held before the first DRP access.
- DRDY_TIMEOUT, 64, maximum cycles from o_den to i_drdy.
- LOCK_TIMEOUT, 65536, maximum cycles from reset release to i_locked.

Ports:
- i_clk  in  1  DRP/control clock.
- i_rst_n  in  1  Asynchronous active-low reset.
- i_req  in  1  Single-cycle start pulse; sampled only in IDLE.
- i_profile  in  $clog2(NUM_PROFILES)  Profile select; captured together with i_req.
- o_busy  out  1  High from request acceptance until DONE or ERR.
- o_done  out  1  One-cycle pulse when lock is achieved.
- o_err  out  1  One-cycle pulse on timeout.
- o_err_code  out  2  Cause of the last error: 01 = DRDY timeout, 10 = lock timeout. Holds until the next request.
- o_tbl_addr  out  $clog2(NUM_PROFILES*ENTRIES)  Table address; table has 1-cycle read latency.
- i_tbl_data  in  39  {drp_addr[38:32], mask[31:16], data[15:0]}.
- o_daddr  out  7  DRP address.
- o_den  out  1  DRP enable, one-cycle pulse.
- o_dwe  out  1  DRP write enable; asserted only together with o_den.
- o_di  out  16  DRP write data.
- i_do  in  16  DRP read data; valid with i_drdy.
- i_drdy  in  1  DRP ready.
- o_mmcm_rst  out  1  Active-high MMCM reset.
- i_locked  in  1  MMCM locked; asynchronous to i_clk, double-flop synchronised internally.
- o_clk_ready  out  1  Output clock is valid for downstream logic.

Behaviour:
- Reset values: o_busy=0, o_done=0, o_err=0, o_err_code=00, o_den=0, o_dwe=0, o_daddr=0, o_di=0, o_tbl_addr=0, o_mmcm_rst=1, o_clk_ready=0.
- After reset the FSM enters WAIT_LOCK directly, with no DRP pass, so that the power-up profile locks.
- Asynchronous reset mid-operation aborts any DRP access. No DRP cleanup is performed.
- FSM states: IDLE, RST_HOLD, FETCH, RD, RD_WAIT, WR, WR_WAIT, RELEASE, WAIT_LOCK, DONE, ERR.
- IDLE: if i_req=1, latch the profile, set o_busy=1, o_clk_ready=0, o_mmcm_rst=1, idx=0, go to RST_HOLD. i_req in any other state is ignored and not queued.
- RST_HOLD: count RST_HOLD cycles, then go to FETCH.
- FETCH: o_tbl_addr = profile*ENTRIES + idx. Data is used in the next cycle, go to RD.
- RD: one-cycle o_den=1, o_dwe=0, o_daddr = tbl[38:32]; start the timeout counter; go to RD_WAIT.
- RD_WAIT: on i_drdy, o_di = (i_do & mask) | (data & ~mask), where mask bit 1 means retain the old bit; go to WR.
- WR: one-cycle o_den=1, o_dwe=1, same o_daddr; go to WR_WAIT.
- WR_WAIT: on i_drdy, if idx = ENTRIES-1 go to RELEASE, else idx+1 and go to FETCH.
- Timeout in RD_WAIT or WR_WAIT: the counter reaches DRDY_TIMEOUT without i_drdy. Set o_err_code=01 and go to ERR.
- A stray i_drdy outside the wait states is ignored.
- RELEASE: o_mmcm_rst=0, clear the lock counter, go to WAIT_LOCK.
- WAIT_LOCK: when synchronised locked=1, go to DONE. If the counter hits LOCK_TIMEOUT, set o_err_code=10 and go to ERR.
- DONE: o_done pulse, o_clk_ready=1, o_busy=0, go to IDLE.
- ERR: o_err pulse, o_mmcm_rst=1, o_busy=0, o_clk_ready=0, go to IDLE. A new request retries.
- In IDLE, o_clk_ready = o_clk_ready & locked_sync, so loss of lock drops it within 3 cycles.
- Sequence latency: RST_HOLD + ENTRIES*(5 + 2 DRDY waits) + 1 + lock time + 1 cycles.

Optional Feature:
- Macro: MMCM_LOCK_RECOVER_EN.
- Defined: in IDLE with o_clk_ready=1, a falling synchronised locked triggers an automatic re-run of the last latched profile. This takes the RST_HOLD path with o_busy=1 and behaves as if i_req had been asserted.
- Not defined: lock loss only deasserts o_clk_ready. The block stays in IDLE until i_req.

Test Plan:
- Power-up: release i_rst_n, DRP model asserts locked 100 cycles after o_mmcm_rst falls -> o_done pulse, o_clk_ready=1, no o_den ever asserted.
- Profile 2 request, ENTRIES=8, DRP returns 0xFFFF, table entry mask=0xF000 data=0x0123 -> writes 0xF123 to each table address. Addresses 16..23 are fetched in order, 8 reads and 8 writes are seen, and o_mmcm_rst is high throughout.
- DRP model never asserts i_drdy on the 3rd read -> o_err pulse 64 cycles after that o_den, o_err_code=01, o_mmcm_rst=1, o_busy=0.
- Lock never returns after RELEASE -> o_err after 65536 cycles, o_err_code=10. A following i_req completes normally.
- i_req pulses during WR_WAIT and reset asserted mid-profile -> the request is ignored; after reset all outputs hold their reset values and the FSM is in WAIT_LOCK.
- Drop i_locked for 10 cycles while in IDLE and ready -> o_clk_ready falls within 3 cycles. With MMCM_LOCK_RECOVER_EN the same profile is reapplied and o_done follows; without it, the FSM stays in IDLE.
